divider_arbiter: RTL and testbench

DIVIDER_ARBITER -- requirements
Module: divider_arbiter

---
 rtl/divider_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_divider_arbiter.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_arbiter.sv
// Round-robin arbiter that shares one external divider among NUM_REQ requesters.
// Each operation runs IDLE -> ISSUE -> WAIT -> RESP. Divide-by-zero and timeout responses are produced locally.
module divider_arbiter #(
    parameter int NUM_REQ           = 4,
    parameter int ID_BITDEPTH       = 2,
    parameter int DIVIDEND_BITDEPTH = 16,
    parameter int DIVISOR_BITDEPTH  = 16,
    parameter int TIMEOUT           = 64
) (
    input  logic                                   i_sclk,
    input  logic                                   i_rst,
    input  logic [NUM_REQ-1:0]                     i_req_valid,
    output logic [NUM_REQ-1:0]                     o_req_ready,
    input  logic [NUM_REQ*DIVIDEND_BITDEPTH-1:0]   i_req_dividend,
    input  logic [NUM_REQ*DIVISOR_BITDEPTH-1:0]    i_req_divisor,
    output logic                                   o_rsp_valid,
    output logic [ID_BITDEPTH-1:0]                 o_rsp_id,
    output logic [DIVIDEND_BITDEPTH-1:0]           o_rsp_quotient,
    output logic [DIVIDEND_BITDEPTH-1:0]           o_rsp_remainder,
    output logic                                   o_rsp_err,
    input  logic                                   i_rsp_ready,
    output logic                                   o_div_valid,
    output logic [DIVIDEND_BITDEPTH-1:0]           o_div_dividend,
    output logic [DIVISOR_BITDEPTH-1:0]            o_div_divisor,
    input  logic                                   i_div_valid,
    input  logic [DIVIDEND_BITDEPTH-1:0]           i_div_quotient,
    input  logic [DIVIDEND_BITDEPTH-1:0]           i_div_remainder,
    output logic                                   o_busy
);

    localparam int                     CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ID_BITDEPTH-1:0] ID_LAST  = ID_BITDEPTH'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [ID_BITDEPTH-1:0]         ptr_q, ptr_d;
    logic [ID_BITDEPTH-1:0]         id_q, id_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           rsp_valid_q, rsp_valid_d;
    logic [ID_BITDEPTH-1:0]         rsp_id_q, rsp_id_d;
    logic [DIVIDEND_BITDEPTH-1:0]   rsp_quotient_q, rsp_quotient_d;
    logic [DIVIDEND_BITDEPTH-1:0]   rsp_remainder_q, rsp_remainder_d;
    logic                           rsp_err_q, rsp_err_d;
    logic                           div_valid_q, div_valid_d;
    logic [DIVIDEND_BITDEPTH-1:0]   div_dividend_q, div_dividend_d;
    logic [DIVISOR_BITDEPTH-1:0]    div_divisor_q, div_divisor_d;
    logic                           busy_q, busy_d;

    logic                           grant_any_s;
    logic [ID_BITDEPTH-1:0]         grant_id_s;
    logic [NUM_REQ-1:0]             grant_onehot_s;
    logic [DIVIDEND_BITDEPTH-1:0]   grant_dividend_s;
    logic [DIVISOR_BITDEPTH-1:0]    grant_divisor_s;
    logic                           sel_s;
    logic [NUM_REQ-1:0]             req_ready_s;

    // Round-robin pick: lowest valid index at/after ptr wins, else lowest valid index below ptr.
    always_comb begin
        grant_any_s      = 1'b0;
        grant_id_s       = '0;
        grant_onehot_s   = '0;
        grant_dividend_s = '0;
        grant_divisor_s  = '0;
        sel_s            = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sel_s            = i_req_valid[k] && (k < int'(ptr_q));
            grant_any_s      = grant_any_s | sel_s;
            grant_id_s       = sel_s ? ID_BITDEPTH'(k) : grant_id_s;
            grant_onehot_s   = sel_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << k) : grant_onehot_s;
            grant_dividend_s = sel_s ? i_req_dividend[k*DIVIDEND_BITDEPTH +: DIVIDEND_BITDEPTH] : grant_dividend_s;
            grant_divisor_s  = sel_s ? i_req_divisor[k*DIVISOR_BITDEPTH +: DIVISOR_BITDEPTH] : grant_divisor_s;
        end
        // The second pass runs last so any hit at or after ptr overrides the wrapped candidate.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sel_s            = i_req_valid[k] && (k >= int'(ptr_q));
            grant_any_s      = grant_any_s | sel_s;
            grant_id_s       = sel_s ? ID_BITDEPTH'(k) : grant_id_s;
            grant_onehot_s   = sel_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << k) : grant_onehot_s;
            grant_dividend_s = sel_s ? i_req_dividend[k*DIVIDEND_BITDEPTH +: DIVIDEND_BITDEPTH] : grant_dividend_s;
            grant_divisor_s  = sel_s ? i_req_divisor[k*DIVISOR_BITDEPTH +: DIVISOR_BITDEPTH] : grant_divisor_s;
        end
    end

    // Next-state and output computation for the one-operation-in-flight FSM.
    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        id_d            = id_q;
        cnt_d           = cnt_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_id_d        = rsp_id_q;
        rsp_quotient_d  = rsp_quotient_q;
        rsp_remainder_d = rsp_remainder_q;
        rsp_err_d       = rsp_err_q;
        div_valid_d     = 1'b0;
        div_dividend_d  = div_dividend_q;
        div_divisor_d   = div_divisor_q;
        req_ready_s     = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_any_s && !i_rst) begin
                    req_ready_s = grant_onehot_s;
                    id_d        = grant_id_s;
                    if (grant_divisor_s != '0) begin
                        state_d        = S_ISSUE;
                        div_valid_d    = 1'b1;
                        div_dividend_d = grant_dividend_s;
                        div_divisor_d  = grant_divisor_s;
                    end else begin
                        // Divide-by-zero is answered locally without starting the divider.
                        state_d         = S_RESP;
                        rsp_valid_d     = 1'b1;
                        rsp_id_d        = grant_id_s;
                        rsp_quotient_d  = '1;
                        rsp_remainder_d = grant_dividend_s;
                        rsp_err_d       = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A result on the expiry cycle still counts as a real result.
                if (i_div_valid) begin
                    state_d         = S_RESP;
                    rsp_valid_d     = 1'b1;
                    rsp_id_d        = id_q;
                    rsp_quotient_d  = i_div_quotient;
                    rsp_remainder_d = i_div_remainder;
                    rsp_err_d       = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d         = S_RESP;
                    rsp_valid_d     = 1'b1;
                    rsp_id_d        = id_q;
                    rsp_quotient_d  = '0;
                    rsp_remainder_d = '0;
                    rsp_err_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    ptr_d       = (id_q == ID_LAST) ? '0 : id_q + ID_BITDEPTH'(1);
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset abandons any operation in flight.
    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            state_q         <= S_IDLE;
            ptr_q           <= '0;
            id_q            <= '0;
            cnt_q           <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_id_q        <= '0;
            rsp_quotient_q  <= '0;
            rsp_remainder_q <= '0;
            rsp_err_q       <= 1'b0;
            div_valid_q     <= 1'b0;
            div_dividend_q  <= '0;
            div_divisor_q   <= '0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            id_q            <= id_d;
            cnt_q           <= cnt_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_id_q        <= rsp_id_d;
            rsp_quotient_q  <= rsp_quotient_d;
            rsp_remainder_q <= rsp_remainder_d;
            rsp_err_q       <= rsp_err_d;
            div_valid_q     <= div_valid_d;
            div_dividend_q  <= div_dividend_d;
            div_divisor_q   <= div_divisor_d;
            busy_q          <= busy_d;
        end
    end

    assign o_req_ready     = req_ready_s;
    assign o_rsp_valid     = rsp_valid_q;
    assign o_rsp_id        = rsp_id_q;
    assign o_rsp_quotient  = rsp_quotient_q;
    assign o_rsp_remainder = rsp_remainder_q;
    assign o_rsp_err       = rsp_err_q;
    assign o_div_valid     = div_valid_q;
    assign o_div_dividend  = div_dividend_q;
    assign o_div_divisor   = div_divisor_q;
    assign o_busy          = busy_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// Scoreboard bench for divider_arbiter: a behavioural divider with programmable latency,
// expected responses queued at request time and checked at each response handshake.
module tb_divider_arbiter;

    localparam int NR  = 4;
    localparam int IDW = 2;
    localparam int DW  = 16;
    localparam int SW  = 16;
    localparam int TO  = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     i_req_valid = '0;
    logic [NR-1:0]     o_req_ready;
    logic [NR*DW-1:0]  i_req_dividend = '0;
    logic [NR*SW-1:0]  i_req_divisor = '0;
    logic              o_rsp_valid;
    logic [IDW-1:0]    o_rsp_id;
    logic [DW-1:0]     o_rsp_quotient;
    logic [DW-1:0]     o_rsp_remainder;
    logic              o_rsp_err;
    logic              i_rsp_ready = 1'b1;
    logic              o_div_valid;
    logic [DW-1:0]     o_div_dividend;
    logic [SW-1:0]     o_div_divisor;
    logic              i_div_valid;
    logic [DW-1:0]     i_div_quotient;
    logic [DW-1:0]     i_div_remainder;
    logic              o_busy;

    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  q;
        logic [DW-1:0]  r;
        logic           err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    bit            div_en    = 1'b1;
    int            div_lat   = 16;
    bit            div_armed = 1'b0;
    int            div_wait  = 0;
    logic [DW-1:0] div_a;
    logic [SW-1:0] div_b;

    always #5 clk = ~clk;

    divider_arbiter #(
        .NUM_REQ(NR), .ID_BITDEPTH(IDW), .DIVIDEND_BITDEPTH(DW),
        .DIVISOR_BITDEPTH(SW), .TIMEOUT(TO)
    ) dut (
        .i_sclk(clk), .i_rst(rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_dividend(i_req_dividend), .i_req_divisor(i_req_divisor),
        .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id),
        .o_rsp_quotient(o_rsp_quotient), .o_rsp_remainder(o_rsp_remainder),
        .o_rsp_err(o_rsp_err), .i_rsp_ready(i_rsp_ready),
        .o_div_valid(o_div_valid), .o_div_dividend(o_div_dividend),
        .o_div_divisor(o_div_divisor), .i_div_valid(i_div_valid),
        .i_div_quotient(i_div_quotient), .i_div_remainder(i_div_remainder),
        .o_busy(o_busy)
    );

    // Divider model: result arrives div_lat cycles after the start pulse.
    initial begin
        i_div_valid     = 1'b0;
        i_div_quotient  = '0;
        i_div_remainder = '0;
        forever begin
            @(posedge clk);
            #1;
            i_div_valid = 1'b0;
            if (div_armed) begin
                div_wait--;
                if (div_wait <= 0) begin
                    i_div_valid     = 1'b1;
                    i_div_quotient  = div_a / DW'(div_b);
                    i_div_remainder = div_a % DW'(div_b);
                    div_armed       = 1'b0;
                end
            end
            if (o_div_valid && div_en) begin
                div_armed = 1'b1;
                div_wait  = div_lat;
                div_a     = o_div_dividend;
                div_b     = o_div_divisor;
            end
        end
    end

    // Response monitor: pop and compare on every handshake cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && o_rsp_valid && i_rsp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got id=%0d q=%0h r=%0h err=%0b, expected no response",
                             o_rsp_id, o_rsp_quotient, o_rsp_remainder, o_rsp_err);
                end else begin
                    e = sb.pop_front();
                    if (o_rsp_id !== e.id || o_rsp_quotient !== e.q ||
                        o_rsp_remainder !== e.r || o_rsp_err !== e.err) begin
                        errors++;
                        $display("FAIL rsp_data: got id=%0d q=%0h r=%0h err=%0b, expected id=%0d q=%0h r=%0h err=%0b",
                                 o_rsp_id, o_rsp_quotient, o_rsp_remainder, o_rsp_err,
                                 e.id, e.q, e.r, e.err);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [DW-1:0] a, input logic [SW-1:0] b);
        i_req_dividend[k*DW +: DW] = a;
        i_req_divisor[k*SW +: SW]  = b;
        i_req_valid[k]             = 1'b1;
    endtask

    task automatic push_exp(input int id, input logic [DW-1:0] q, input logic [DW-1:0] r, input logic err);
        exp_t e;
        e.id  = IDW'(id);
        e.q   = q;
        e.r   = r;
        e.err = err;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || o_rsp_valid) && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d responses outstanding, expected 0", name, sb.size());
        end
    endtask

    task automatic wait_rsp(output int n);
        n = 1;
        while (!o_rsp_valid && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        i_req_valid = 4'b1111;
        step();
        step();
        @(negedge clk);
        checks++;
        if (o_req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b, expected 0000", o_req_ready);
        end
        checks++;
        if ({o_rsp_valid, o_rsp_id, o_rsp_quotient, o_rsp_remainder, o_rsp_err,
             o_div_valid, o_div_dividend, o_div_divisor, o_busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b id=%0d q=%0h r=%0h e=%b dv=%b dd=%0h ds=%0h busy=%b, expected all 0",
                     o_rsp_valid, o_rsp_id, o_rsp_quotient, o_rsp_remainder, o_rsp_err,
                     o_div_valid, o_div_dividend, o_div_divisor, o_busy);
        end
        step();
        i_req_valid = '0;
        rst         = 1'b0;
        step();
    endtask

    task automatic test_single();
        int n;
        div_en  = 1'b1;
        div_lat = 16;
        set_req(0, 16'd1000, 16'd7);
        push_exp(0, 16'd142, 16'd6, 1'b0);
        @(negedge clk);
        checks++;
        if (o_req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant: got %b, expected 0001", o_req_ready);
        end
        step();
        i_req_valid = '0;
        checks++;
        if (o_div_valid !== 1'b1 || o_div_dividend !== 16'd1000 || o_div_divisor !== 16'd7 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_issue: got dv=%b dd=%0d ds=%0d busy=%b, expected 1 1000 7 1",
                     o_div_valid, o_div_dividend, o_div_divisor, o_busy);
        end
        n = 1;
        while (!o_rsp_valid && n < 200) begin
            step();
            n++;
            if (n == 2) begin
                checks++;
                if (o_div_valid !== 1'b0 || o_div_dividend !== 16'd1000 || o_div_divisor !== 16'd7) begin
                    errors++;
                    $display("FAIL single_hold: got dv=%b dd=%0d ds=%0d, expected 0 1000 7",
                             o_div_valid, o_div_dividend, o_div_divisor);
                end
            end
        end
        checks++;
        if (n != 18) begin
            errors++;
            $display("FAIL single_latency: got T+%0d, expected T+18", n);
        end
        wait_drain("single");
    endtask

    task automatic test_all_four();
        int            order[5] = '{0, 1, 2, 3, 0};
        logic [NR-1:0] exp_rdy;
        int            n;
        int            a;
        int            b;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        div_lat = 5;
        for (int k = 0; k < NR; k++) begin
            set_req(k, DW'((k + 1) * 1111), SW'(k + 3));
        end
        for (int j = 0; j < 5; j++) begin
            n = 0;
            @(negedge clk);
            while (o_req_ready == '0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            exp_rdy = 4'b0001;
            exp_rdy = exp_rdy << order[j];
            a = (order[j] + 1) * 1111;
            b = order[j] + 3;
            checks++;
            if (o_req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rr_grant%0d: got %b, expected %b", j, o_req_ready, exp_rdy);
            end
            push_exp(order[j], DW'(a / b), DW'(a % b), 1'b0);
            step();
            if (j == 4) begin
                i_req_valid = '0;
            end
            @(negedge clk);
            checks++;
            if (o_req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL rr_pulse%0d: got %b, expected 0000", j, o_req_ready);
            end
        end
        wait_drain("rr");
    endtask

    task automatic test_div_zero();
        i_req_dividend = '0;
        i_req_divisor  = '0;
        set_req(2, 16'h1234, 16'h0000);
        push_exp(2, 16'hFFFF, 16'h1234, 1'b1);
        @(negedge clk);
        checks++;
        if (o_req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL dz_grant: got %b, expected 0100", o_req_ready);
        end
        step();
        i_req_valid = '0;
        checks++;
        if (o_rsp_valid !== 1'b1 || o_div_valid !== 1'b0) begin
            errors++;
            $display("FAIL dz_latency: got rsp_valid=%b div_valid=%b at T+1, expected 1 0", o_rsp_valid, o_div_valid);
        end
        step();
        checks++;
        if (o_div_valid !== 1'b0 || o_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL dz_after: got div_valid=%b rsp_valid=%b, expected 0 0", o_div_valid, o_rsp_valid);
        end
        wait_drain("dz");
    endtask

    task automatic test_timeout();
        int n;
        for (int v = 0; v < 2; v++) begin
            div_en  = (v == 1);
            div_lat = TO;
            set_req(1, 16'd500, 16'd3);
            if (v == 0) push_exp(1, 16'd0, 16'd0, 1'b1);
            else        push_exp(1, 16'd166, 16'd2, 1'b0);
            @(negedge clk);
            checks++;
            if (o_req_ready !== 4'b0010) begin
                errors++;
                $display("FAIL to_grant%0d: got %b, expected 0010", v, o_req_ready);
            end
            step();
            i_req_valid = '0;
            wait_rsp(n);
            checks++;
            if (n != TO + 2) begin
                errors++;
                $display("FAIL to_latency%0d: got T+%0d, expected T+%0d", v, n, TO + 2);
            end
            wait_drain("to");
        end
        div_en = 1'b1;
    endtask

    task automatic test_backpressure();
        int n;
        div_lat     = 3;
        i_rsp_ready = 1'b0;
        set_req(3, 16'd9999, 16'd10);
        set_req(0, 16'd77, 16'd5);
        push_exp(3, 16'd999, 16'd9, 1'b0);
        @(negedge clk);
        checks++;
        if (o_req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL bp_grant: got %b, expected 1000", o_req_ready);
        end
        step();
        i_req_valid[3] = 1'b0;
        wait_rsp(n);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (o_rsp_valid !== 1'b1 || o_rsp_id !== 2'd3 || o_rsp_quotient !== 16'd999 ||
                o_rsp_remainder !== 16'd9 || o_rsp_err !== 1'b0 || o_req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b id=%0d q=%0d r=%0d e=%b rdy=%b, expected 1 3 999 9 0 0000",
                         i, o_rsp_valid, o_rsp_id, o_rsp_quotient, o_rsp_remainder, o_rsp_err, o_req_ready);
            end
        end
        step();
        i_rsp_ready = 1'b1;
        push_exp(0, 16'd15, 16'd2, 1'b0);
        @(negedge clk);
        checks++;
        if (o_req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_hs_cycle: got %b, expected 0000", o_req_ready);
        end
        step();
        @(negedge clk);
        checks++;
        if (o_req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp_next_grant: got %b, expected 0001", o_req_ready);
        end
        step();
        i_req_valid = '0;
        wait_drain("bp");
    endtask

    task automatic test_reset_wait();
        div_lat = 10;
        set_req(1, 16'd4321, 16'd5);
        @(negedge clk);
        checks++;
        if (o_req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL rw_grant: got %b, expected 0010", o_req_ready);
        end
        step();
        i_req_valid = '0;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_div_valid !== 1'b0 || o_div_dividend !== 16'd0 || o_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rw_async: got busy=%b dv=%b dd=%0d rv=%b, expected 0 0 0 0",
                     o_busy, o_div_valid, o_div_dividend, o_rsp_valid);
        end
        for (int i = 0; i < 4; i++) step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (o_rsp_valid !== 1'b0 || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL rw_stale%0d: got rsp_valid=%b busy=%b, expected 0 0", i, o_rsp_valid, o_busy);
            end
        end
        set_req(2, 16'd100, 16'd9);
        push_exp(2, 16'd11, 16'd1, 1'b0);
        @(negedge clk);
        checks++;
        if (o_req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL rw_next_grant: got %b, expected 0100", o_req_ready);
        end
        step();
        i_req_valid = '0;
        wait_drain("rw");
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_div_zero();
        test_timeout();
        test_backpressure();
        test_reset_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
